// File: rtl/sga_uc_if.sv
// Snake Game Arcade control-unit bus.
// Groups the controller's status inputs (player controls and datapath flags)
// and its control outputs (datapath strobes, direction, status and debug state).
//   master : the control unit (sga_uc) - receives controls/flags, drives strobes
//   slave  : the environment/datapath  - drives controls/flags, receives strobes
interface sga_uc_if;
  // player controls and datapath status flags
  logic       start;
  logic       restart;
  logic [3:0] buttons;
  logic       render_finish;
  logic       apple_eaten;
  logic       collision;
  logic       size_full;
  // datapath strobes
  logic       clear_size;
  logic       load_size;
  logic       count_size;
  logic       render_clr;
  logic       render_count;
  logic       register_apple;
  logic       reset_apple;
  logic       move;
  // direction and game status
  logic [1:0] direction;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic [3:0] db_estado;

  modport master (
    input  start, restart, buttons, render_finish, apple_eaten, collision, size_full,
    output clear_size, load_size, count_size, render_clr, render_count,
           register_apple, reset_apple, move, direction, pronto, ganhou, perdeu, db_estado
  );

  modport slave (
    output start, restart, buttons, render_finish, apple_eaten, collision, size_full,
    input  clear_size, load_size, count_size, render_clr, render_count,
           register_apple, reset_apple, move, direction, pronto, ganhou, perdeu, db_estado
  );
endinterface

// File: rtl/sga_uc.sv
// Snake Game Arcade control unit.
// Sequences the datapath: prepares a game, places apples, renders the snake,
// paces moves with a tick counter, latches the player's direction and decides
// grow / lose / win after every move.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-low, highest priority
//   bus   : sga_uc_if.master - controls/flags in, strobes/status out
module sga_uc #(
  parameter int MOVE_PERIOD = 25_000_000
) (
  input  logic     clock,
  input  logic     reset,
  sga_uc_if.master bus
);

  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_PERIOD - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    NOVA_MACA  = 4'd2,
    ESPERA     = 4'd3,
    MOVE       = 4'd4,
    VERIFICA   = 4'd5,
    CRESCE     = 4'd6,
    RENDER_INI = 4'd7,
    RENDER     = 4'd8,
    PERDEU     = 4'd14,
    GANHOU     = 4'd15
  } state_t;

  state_t        state_r, state_next_s;
  logic [TW-1:0] tick_r, tick_next_s;
  logic [1:0]    dir_r, dir_next_s;

  logic clear_size_s, load_size_s, count_size_s, render_clr_s, render_count_s;
  logic register_apple_s, reset_apple_s, move_s;

  // True when exactly one button is pressed.
  function automatic logic is_onehot4(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

  // Encode a one-hot button vector into a direction code.
  function automatic logic [1:0] btn_to_dir(input logic [3:0] b);
    logic [1:0] d;
    case (b)
      4'b0001: d = 2'b00;
      4'b0010: d = 2'b01;
      4'b0100: d = 2'b10;
      4'b1000: d = 2'b11;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // Opposite directions share the axis bit [1] and differ in bit [0].
  function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] req);
    return (cur[1] == req[1]) && (cur[0] != req[0]);
  endfunction

  // Next-state, counter/direction update and Moore/Mealy strobe decode.
  always_comb begin
    state_next_s     = state_r;
    tick_next_s      = tick_r;
    dir_next_s       = dir_r;
    clear_size_s     = 1'b0;
    load_size_s      = 1'b0;
    count_size_s     = 1'b0;
    render_clr_s     = 1'b0;
    render_count_s   = 1'b0;
    register_apple_s = 1'b0;
    reset_apple_s    = 1'b0;
    move_s           = 1'b0;

    case (state_r)
      INICIAL: begin
        if (bus.start) state_next_s = PREPARA;
        else           state_next_s = INICIAL;
      end
      PREPARA: begin
        clear_size_s  = 1'b1;
        load_size_s   = 1'b1;
        reset_apple_s = 1'b1;
        render_clr_s  = 1'b1;
        dir_next_s    = 2'b00;
        tick_next_s   = '0;
        state_next_s  = NOVA_MACA;
      end
      NOVA_MACA: begin
        register_apple_s = 1'b1;
        state_next_s     = RENDER_INI;
      end
      ESPERA: begin
        // direction may change on the same edge that leaves for MOVE
        if (is_onehot4(bus.buttons) && !is_reversal(dir_r, btn_to_dir(bus.buttons))) begin
          dir_next_s = btn_to_dir(bus.buttons);
        end else begin
          dir_next_s = dir_r;
        end
        if (tick_r == TICK_LAST) begin
          tick_next_s  = '0;
          state_next_s = MOVE;
        end else begin
          tick_next_s  = tick_r + TW'(1);
          state_next_s = ESPERA;
        end
      end
      MOVE: begin
        move_s       = 1'b1;
        state_next_s = VERIFICA;
      end
      VERIFICA: begin
        if (bus.collision)        state_next_s = PERDEU;
        else if (bus.apple_eaten) state_next_s = CRESCE;
        else                      state_next_s = RENDER_INI;
      end
      CRESCE: begin
        count_size_s = 1'b1;
        // size_full reflects the size before this increment
        if (bus.size_full) state_next_s = GANHOU;
        else               state_next_s = NOVA_MACA;
      end
      RENDER_INI: begin
        render_clr_s = 1'b1;
        state_next_s = RENDER;
      end
      RENDER: begin
        render_count_s = ~bus.render_finish;
        if (bus.render_finish) state_next_s = ESPERA;
        else                   state_next_s = RENDER;
      end
      PERDEU, GANHOU: begin
        if (bus.start) state_next_s = PREPARA;
        else           state_next_s = state_r;
      end
      default: begin
        state_next_s = INICIAL;
      end
    endcase

    // restart overrides only the next state; this cycle's strobes stand
    case (state_r)
      PREPARA, NOVA_MACA, ESPERA, MOVE, VERIFICA, CRESCE, RENDER_INI, RENDER: begin
        if (bus.restart) state_next_s = PREPARA;
        else             state_next_s = state_next_s;
      end
      default: begin
        state_next_s = state_next_s;
      end
    endcase
  end

  // State, tick counter and direction registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= INICIAL;
      tick_r  <= '0;
      dir_r   <= 2'b00;
    end else begin
      state_r <= state_next_s;
      tick_r  <= tick_next_s;
      dir_r   <= dir_next_s;
    end
  end

  assign bus.clear_size     = clear_size_s;
  assign bus.load_size      = load_size_s;
  assign bus.count_size     = count_size_s;
  assign bus.render_clr     = render_clr_s;
  assign bus.render_count   = render_count_s;
  assign bus.register_apple = register_apple_s;
  assign bus.reset_apple    = reset_apple_s;
  assign bus.move           = move_s;
  assign bus.direction      = dir_r;
  assign bus.pronto         = (state_r == INICIAL) || (state_r == PERDEU) || (state_r == GANHOU);
  assign bus.ganhou         = (state_r == GANHOU);
  assign bus.perdeu         = (state_r == PERDEU);
  assign bus.db_estado      = state_r;

endmodule

// File: tb/tb_sga_uc.sv
// Self-checking bench for sga_uc with MOVE_PERIOD=4.
module tb_sga_uc;
  localparam int MP = 4;
  localparam logic [7:0] S_CLR = 8'h80, S_LOAD = 8'h40, S_CNT = 8'h20, S_RCLR = 8'h10;
  localparam logic [7:0] S_RCNT = 8'h08, S_RAPL = 8'h04, S_RSTA = 8'h02, S_MOVE = 8'h01;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [1:0] exp_dir;

  sga_uc_if bus ();
  sga_uc #(.MOVE_PERIOD(MP)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] strobes();
    return {bus.clear_size, bus.load_size, bus.count_size, bus.render_clr,
            bus.render_count, bus.register_apple, bus.reset_apple, bus.move};
  endfunction

  // Reference rule: the opposite of each direction code (right/left, up/down).
  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      2'd0: return 2'd1;
      2'd1: return 2'd0;
      2'd2: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [15:0] make_btns();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) != 0) v[4*i +: 4] = 4'(4'b0001 << $urandom_range(0, 3));
      else                           v[4*i +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_checks++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.db_estado); end
    n_checks++; if (strobes() !== 8'h00) begin n_fail++; $display("FAIL reset_strobes: got %h expected 00", strobes()); end
    n_checks++; if ({bus.pronto, bus.ganhou, bus.perdeu} !== 3'b100) begin n_fail++; $display("FAIL reset_status: got %b expected 100", {bus.pronto, bus.ganhou, bus.perdeu}); end
    n_checks++; if (bus.direction !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", bus.direction); end
    reset = 1'b1;
    exp_dir = 2'b00;
    step();
    n_checks++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL idle_hold: got %0d expected 0", bus.db_estado); end
  endtask

  // From a ready state: start a game and walk PREPARA, NOVA_MACA, RENDER_INI into RENDER.
  task automatic do_prepare();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++; if (bus.db_estado !== 4'd1) begin n_fail++; $display("FAIL prep_state: got %0d expected 1", bus.db_estado); end
    n_checks++; if (strobes() !== (S_CLR | S_LOAD | S_RSTA | S_RCLR)) begin n_fail++; $display("FAIL prep_strobes: got %h expected %h", strobes(), S_CLR | S_LOAD | S_RSTA | S_RCLR); end
    n_checks++; if (bus.pronto !== 1'b0) begin n_fail++; $display("FAIL prep_pronto: got %b expected 0", bus.pronto); end
    step();
    exp_dir = 2'b00;
    n_checks++; if (bus.db_estado !== 4'd2) begin n_fail++; $display("FAIL apple_state: got %0d expected 2", bus.db_estado); end
    n_checks++; if (strobes() !== S_RAPL) begin n_fail++; $display("FAIL apple_strobes: got %h expected %h", strobes(), S_RAPL); end
    n_checks++; if (bus.direction !== exp_dir) begin n_fail++; $display("FAIL prep_dir: got %0d expected %0d", bus.direction, exp_dir); end
    step();
    n_checks++; if (bus.db_estado !== 4'd7) begin n_fail++; $display("FAIL rini_state: got %0d expected 7", bus.db_estado); end
    n_checks++; if (strobes() !== S_RCLR) begin n_fail++; $display("FAIL rini_strobes: got %h expected %h", strobes(), S_RCLR); end
    step();
    n_checks++; if (bus.db_estado !== 4'd8) begin n_fail++; $display("FAIL render_entry: got %0d expected 8", bus.db_estado); end
  endtask

  // In RENDER: render_finish rises on cycle k, so render_count is high for k-1 cycles.
  task automatic do_render(input int k);
    for (int i = 1; i <= k; i++) begin
      bus.render_finish = (i == k);
      #1;
      n_checks++; if (bus.db_estado !== 4'd8) begin n_fail++; $display("FAIL render_state: got %0d expected 8", bus.db_estado); end
      n_checks++; if (strobes() !== ((i != k) ? S_RCNT : 8'h00)) begin n_fail++; $display("FAIL render_count: cycle %0d got %h expected %h", i, strobes(), (i != k) ? S_RCNT : 8'h00); end
      step();
    end
    bus.render_finish = 1'b0;
    n_checks++; if (bus.db_estado !== 4'd3) begin n_fail++; $display("FAIL espera_entry: got %0d expected 3", bus.db_estado); end
  endtask

  // In ESPERA: apply one button nibble per cycle, track direction, expect MP cycles then MOVE.
  task automatic do_espera(input logic [15:0] btns);
    int n;
    logic [3:0] b;
    logic [1:0] nd;
    n = 0;
    while (bus.db_estado === 4'd3 && n < 20) begin
      b = (n < 4) ? btns[4*n +: 4] : 4'd0;
      bus.buttons = b;
      #1;
      n_checks++; if (strobes() !== 8'h00 || bus.pronto !== 1'b0) begin n_fail++; $display("FAIL espera_quiet: got %h/%b expected 00/0", strobes(), bus.pronto); end
      step();
      if ($countones(b) == 1) begin
        nd = 2'd0;
        for (int j = 0; j < 4; j++) if (b[j]) nd = 2'(j);
        if (nd != opposite(exp_dir)) exp_dir = nd;
      end
      n++;
      n_checks++; if (bus.direction !== exp_dir) begin n_fail++; $display("FAIL direction: btn %b got %0d expected %0d", b, bus.direction, exp_dir); end
    end
    bus.buttons = 4'd0;
    n_checks++; if (n != MP) begin n_fail++; $display("FAIL espera_len: got %0d expected %0d", n, MP); end
    n_checks++; if (bus.db_estado !== 4'd4 || strobes() !== S_MOVE) begin n_fail++; $display("FAIL move_pulse: got %0d/%h expected 4/%h", bus.db_estado, strobes(), S_MOVE); end
  endtask

  // From MOVE: step into VERIFICA, present flags and check the resulting path.
  task automatic do_verify(input bit col, input bit apl, input bit full, output bit ended);
    logic [3:0] st;
    ended = 1'b0;
    step();
    n_checks++; if (bus.db_estado !== 4'd5 || strobes() !== 8'h00) begin n_fail++; $display("FAIL verifica: got %0d/%h expected 5/00", bus.db_estado, strobes()); end
    bus.collision = col;
    bus.apple_eaten = apl;
    step();
    bus.collision = 1'b0;
    bus.apple_eaten = 1'b0;
    if (col) begin
      ended = 1'b1;
      n_checks++; if (bus.db_estado !== 4'd14 || strobes() !== 8'h00) begin n_fail++; $display("FAIL lose: got %0d/%h expected 14/00", bus.db_estado, strobes()); end
      n_checks++; if ({bus.pronto, bus.ganhou, bus.perdeu} !== 3'b101) begin n_fail++; $display("FAIL lose_status: got %b expected 101", {bus.pronto, bus.ganhou, bus.perdeu}); end
    end else if (apl) begin
      n_checks++; if (bus.db_estado !== 4'd6 || strobes() !== S_CNT) begin n_fail++; $display("FAIL grow: got %0d/%h expected 6/%h", bus.db_estado, strobes(), S_CNT); end
      bus.size_full = full;
      step();
      bus.size_full = 1'b0;
      if (full) begin
        ended = 1'b1;
        n_checks++; if (bus.db_estado !== 4'd15 || strobes() !== 8'h00) begin n_fail++; $display("FAIL win: got %0d/%h expected 15/00", bus.db_estado, strobes()); end
        n_checks++; if ({bus.pronto, bus.ganhou, bus.perdeu} !== 3'b110) begin n_fail++; $display("FAIL win_status: got %b expected 110", {bus.pronto, bus.ganhou, bus.perdeu}); end
      end else begin
        n_checks++; if (bus.db_estado !== 4'd2 || strobes() !== S_RAPL) begin n_fail++; $display("FAIL grow_apple: got %0d/%h expected 2/%h", bus.db_estado, strobes(), S_RAPL); end
        step();
        n_checks++; if (bus.db_estado !== 4'd7) begin n_fail++; $display("FAIL grow_rini: got %0d expected 7", bus.db_estado); end
        step();
      end
    end else begin
      n_checks++; if (bus.db_estado !== 4'd7 || strobes() !== S_RCLR) begin n_fail++; $display("FAIL plain_rini: got %0d/%h expected 7/%h", bus.db_estado, strobes(), S_RCLR); end
      step();
    end
    if (ended) begin
      st = bus.db_estado;
      step();
      n_checks++; if (bus.db_estado !== st) begin n_fail++; $display("FAIL end_hold: got %0d expected %0d", bus.db_estado, st); end
    end else begin
      n_checks++; if (bus.db_estado !== 4'd8) begin n_fail++; $display("FAIL back_render: got %0d expected 8", bus.db_estado); end
    end
  endtask

  task automatic test_start_sequence();
    do_prepare();
    do_render(3);
    do_espera(16'h0000);
  endtask

  task automatic test_direction();
    bit e;
    do_verify(1'b0, 1'b0, 1'b0, e);
    do_render(1);
    do_espera({4'b0000, 4'b0101, 4'b0100, 4'b0010});
    n_checks++; if (bus.direction !== 2'b10) begin n_fail++; $display("FAIL dir_up: got %0d expected 2", bus.direction); end
  endtask

  task automatic test_grow_and_win();
    bit e;
    do_verify(1'b0, 1'b1, 1'b0, e);
    do_render(2);
    do_espera(make_btns());
    do_verify(1'b0, 1'b1, 1'b1, e);
  endtask

  task automatic test_lose();
    bit e;
    do_prepare();
    do_render(1);
    do_espera(16'h0008);
    do_verify(1'b1, 1'b1, 1'b0, e);
  endtask

  task automatic test_restart();
    bit e;
    do_prepare();
    bus.restart = 1'b1;
    #1;
    n_checks++; if (strobes() !== S_RCNT) begin n_fail++; $display("FAIL restart_strobe: got %h expected %h", strobes(), S_RCNT); end
    step();
    bus.restart = 1'b0;
    n_checks++; if (bus.db_estado !== 4'd1) begin n_fail++; $display("FAIL restart_state: got %0d expected 1", bus.db_estado); end
    step();
    step();
    step();
    do_render(2);
    step();
    step();
    n_checks++; if (bus.db_estado !== 4'd3) begin n_fail++; $display("FAIL espera_mid: got %0d expected 3", bus.db_estado); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_dir = 2'b00;
    n_checks++; if (bus.db_estado !== 4'd0 || strobes() !== 8'h00 || bus.pronto !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got %0d/%h/%b expected 0/00/1", bus.db_estado, strobes(), bus.pronto); end
    do_prepare();
    do_render(1);
    do_espera(16'h0000);
    do_verify(1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic test_random_games();
    bit e;
    bit col, apl, full;
    for (int g = 0; g < 12; g++) begin
      do_prepare();
      for (int r = 0; r < 30; r++) begin
        do_render($urandom_range(1, 4));
        do_espera(make_btns());
        col  = ($urandom_range(0, 4) == 0) || (r == 29);
        apl  = $urandom_range(0, 1) == 1;
        full = $urandom_range(0, 3) == 0;
        do_verify(col, apl, full, e);
        if (e) break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_dir = 2'b00;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.restart = 1'b0;
    bus.buttons = 4'd0;
    bus.render_finish = 1'b0;
    bus.apple_eaten = 1'b0;
    bus.collision = 1'b0;
    bus.size_full = 1'b0;
    test_reset();
    test_start_sequence();
    test_direction();
    test_grow_and_win();
    test_lose();
    test_restart();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sga_uc.md
Name: sga_uc

Overview:
- Control unit (FSM) that sequences the Snake Game Arcade datapath.
- Paces snake moves with an internal tick counter and latches the player's direction from the buttons.
- Drives the datapath strobes for size, apple and render, and walks the render counter until render_finish.
- Sits beside the datapath at the top level. All datapath control inputs are active-high strobes generated here.

Parameters:
MOVE_PERIOD  25_000_000  clock cycles between snake moves (>=2); tick counter width = $clog2(MOVE_PERIOD)

Ports:
clock           input   1  system clock, all logic rising-edge
reset           input   1  synchronous, active-low; all state/outputs to reset values on the clock edge where reset=0
start           input   1  level; begins a game from INICIAL, PERDEU or GANHOU
restart         input   1  level; aborts a running game back to PREPARA
buttons         input   4  one-hot direction request: [0]=right [1]=left [2]=up [3]=down
render_finish   input   1  datapath: render counter equals snake size
apple_eaten     input   1  datapath: head equals apple position (valid in VERIFICA)
collision       input   1  datapath: head hit body or wall (valid in VERIFICA)
size_full       input   1  datapath: size counter at 15
clear_size      output  1  clear snake size counter
load_size       output  1  load size counter with 1
count_size      output  1  increment size counter
render_clr      output  1  clear render counter
render_count    output  1  increment render counter
register_apple  output  1  capture new apple position
reset_apple     output  1  clear apple register
move            output  1  one-cycle pulse: advance snake head by direction
direction       output  2  00 right, 01 left, 10 up, 11 down
pronto          output  1  high in INICIAL, PERDEU, GANHOU
ganhou          output  1  high in GANHOU
perdeu          output  1  high in PERDEU
db_estado       output  4  current state code

Behaviour:
- States (db_estado code):
  - INICIAL 0
  - PREPARA 1
  - NOVA_MACA 2
  - ESPERA 3
  - MOVE 4
  - VERIFICA 5
  - CRESCE 6
  - RENDER_INI 7
  - RENDER 8
  - PERDEU 14
  - GANHOU 15
- Unused codes return to INICIAL on the next cycle.
- Reset (reset=0): state=INICIAL, direction=00, tick counter=0. All strobes are 0; pronto=1, ganhou=0, perdeu=0. Reset has priority over everything.
- restart=1 in any state other than INICIAL/PERDEU/GANHOU: next state is PREPARA, and the current state's strobes are still issued this cycle.
- Transitions and Moore outputs:
  - INICIAL: start=1 -> PREPARA.
  - PREPARA (1 cycle): clear_size=1, load_size=1, reset_apple=1, render_clr=1. Also direction<=00 and tick<=0. Next state is NOVA_MACA.
  - NOVA_MACA (1 cycle): register_apple=1. Next state is RENDER_INI.
  - ESPERA: tick increments each cycle. When tick==MOVE_PERIOD-1, tick<=0 and next state is MOVE, so exactly MOVE_PERIOD cycles are spent in ESPERA.
  - MOVE (1 cycle): move=1. Next state is VERIFICA.
  - VERIFICA (1 cycle):
    - collision=1 -> PERDEU; collision takes priority over apple_eaten.
    - else apple_eaten=1 -> CRESCE.
    - else -> RENDER_INI.
  - CRESCE (1 cycle): count_size=1. size_full=1 (sampled this cycle, before increment) -> GANHOU, else -> NOVA_MACA.
  - RENDER_INI (1 cycle): render_clr=1. Next state is RENDER.
  - RENDER: render_count = ~render_finish (Mealy). render_finish=1 -> ESPERA.
  - PERDEU/GANHOU: hold. start=1 -> PREPARA.
- Direction register:
  - Updates only in ESPERA, and only when buttons has exactly one bit set.
  - Zero or multiple bits set: no change.
  - A request that reverses the current direction (right<->left, up<->down) is ignored.
  - An update and the ESPERA->MOVE transition in the same cycle are both honoured; the move uses the new direction on the next cycle.
- Counter width: tick never exceeds MOVE_PERIOD-1 and wraps to 0 only on the MOVE transition.

Test Plan:
1. MOVE_PERIOD=4: reset=0 for 2 cycles, then reset=1 -> state 0, all strobes 0, pronto=1, direction=00.
2. start=1 from INICIAL -> db_estado sequence 1,2,7,8. In PREPARA, clear_size=load_size=reset_apple=render_clr=1. With render_finish rising on the 3rd RENDER cycle, render_count=1 for exactly 2 cycles, then state 3 for 4 cycles, then move=1 for 1 cycle.
3. In ESPERA with direction=00: buttons=0010 ignored (reversal); buttons=0100 -> direction=10; buttons=0101 -> no change.
4. In VERIFICA, apple_eaten=1, size_full=0 -> states 6,2,7; count_size and register_apple each pulse once. With size_full=1 -> state 15, ganhou=1, pronto=1.
5. In VERIFICA, collision=1 and apple_eaten=1 -> state 14, perdeu=1, count_size never asserted. Then start=1 -> PREPARA, direction=00.
6. restart=1 during RENDER -> PREPARA next cycle. reset=0 during ESPERA with tick=2 -> INICIAL, tick=0 next cycle.
